seq_input_cond: RTL
===================

# seq_input_cond

Input conditioning stage sitting directly upstream of the board-level sequence-detector FSM. Takes the raw push-button (`btn_next`) and slide-switch (`sw_in`) pins and synchronises and debounces both. It produces a clean button level, a single-cycle press pulse and a stable switch level, which drive the FSM's `next` and `in` inputs. It also keeps a wrap-around count of accepted presses for debug display.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000, consecutive synchronised cycles a new input value must hold before it is accepted (10 ms at 100 MHz); legal range >= 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, width of each debounce counter.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; while 0 all registers hold their reset values.
- `btn_next`  in  1  raw, asynchronous, bouncing push-button.
- `sw_in`  in  1  raw, asynchronous, bouncing slide switch.
- `next_level`  out  1  debounced button level (feeds FSM `next`).
- `next_pulse`  out  1  one-cycle strobe on each accepted press.
- `in_sync`  out  1  debounced switch level (feeds FSM `in`).
- `press_count`  out  8  number of accepted presses, modulo 256.

## Operation
- Synchronisers: each raw input passes through a 2-flop synchroniser (`s1`, `s2`). The debouncers see only `s2`.
- Debouncer (one per input, identical): keeps a debounced level `lvl` and a counter `cnt`.
  - If `s2 == lvl`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl` <= `s2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
- Button FSM, 4 states encoded in 2 bits:
  - B_LOW: `lvl`=0 and `cnt`=0.
  - B_RISE: `lvl`=0 and counting.
  - B_HIGH: `lvl`=1 and `cnt`=0.
  - B_FALL: `lvl`=1 and counting.
- Button FSM transitions:
  - B_LOW -> B_RISE when `s2`=1.
  - B_RISE -> B_LOW when `s2`=0 (bounce rejected; `cnt` cleared).
  - B_RISE -> B_HIGH when the count expires.
  - B_HIGH -> B_FALL when `s2`=0.
  - B_FALL -> B_HIGH when `s2`=1.
  - B_FALL -> B_LOW when the count expires.
- The switch uses the same debouncer structure. An FSM view is optional because its outputs are identical.
- `next_pulse` is registered. It is 1 for exactly the one cycle following the B_RISE->B_HIGH edge, i.e. the first cycle `next_level` reads 1. It is 0 at all other times, including release.
- `press_count` increments on the same edge `next_pulse` is set and wraps 255 -> 0. No saturation.
- Filtering rule: a raw change is accepted only if it holds for >= `DEBOUNCE_CYCLES` clock cycles. Any shorter excursion produces no output change.
- Each input is fully independent. A switch change and a button press may be accepted on the same edge.
- Switch settling: the switch must be settled before the press is accepted. A press and a switch change accepted on the same edge leave the FSM sampling the new `in_sync` one cycle later, because `in_sync` is registered like `next_level`.

## Timing
- Reset values (async, immediate on `reset`=0):
  - `next_level`=0, `next_pulse`=0, `in_sync`=0, `press_count`=0.
  - Synchronisers, counters and FSM cleared to B_LOW.
- After reset deasserts, the first sample is taken on the next rising `clk`.
- If a switch is held at 1 through reset, it is reported after the normal latency; no special case.
- Latency: raw change -> output change = 2 + `DEBOUNCE_CYCLES` rising edges, counted from the first edge that samples the new value.
- `next_pulse` is coincident with the rising `next_level`. `press_count` shows the new value in that same cycle.
- Reset asserted mid-count: the counter and FSM are cleared and no pulse is emitted. After release, a still-held button is re-qualified from scratch, giving one pulse after the full latency.
- Counter width: the count never exceeds `DEBOUNCE_CYCLES-1`, so no overflow. `CNT_W` must hold `DEBOUNCE_CYCLES-1`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: drive `reset`=0 mid-cycle with inputs high -> all outputs 0 immediately, without waiting for a clock edge.
- Clean press: `btn_next` 0->1 held -> `next_level`=1 after the 6th edge. `next_pulse`=1 for exactly that one cycle. `press_count`=1.
- Bounce rejection: `btn_next` high 3 cycles, low 1, high 3, then low -> `next_level` stays 0, no pulse, `press_count`=0.
- Release: after the press, drop `btn_next` -> `next_level`=0 six edges later, with no `next_pulse`.
- Wrap: 256 clean presses -> `press_count` returns to 0, with exactly 256 single-cycle pulses.
- Simultaneous: `sw_in` and `btn_next` rise on the same cycle -> `in_sync` and `next_level` both go to 1 on the 6th edge. A bench model of the FSM stepping on `next_pulse` sees `in`=1.
- Reset mid-count: assert `reset` two cycles after `btn_next` rises, release it, and keep the button held -> exactly one pulse, six edges after the first post-reset edge.

Source files
------------

// File: rtl/seq_input_cond_if.sv
// Signal bundle between the raw board pins, the input conditioner and the
// downstream sequence-detector FSM.
interface seq_input_cond_if;
    logic       btn_next;
    logic       sw_in;
    logic       next_level;
    logic       next_pulse;
    logic       in_sync;
    logic [7:0] press_count;

    modport master (
        output btn_next,
        output sw_in,
        input  next_level,
        input  next_pulse,
        input  in_sync,
        input  press_count
    );

    modport slave (
        input  btn_next,
        input  sw_in,
        output next_level,
        output next_pulse,
        output in_sync,
        output press_count
    );
endinterface

// File: rtl/seq_input_cond.sv
// Synchronises and debounces the push-button and slide switch, producing a
// clean button level, a one-cycle press strobe, a clean switch level and a press count.
module seq_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    seq_input_cond_if.slave  bus
);

    typedef enum logic [1:0] {
        B_LOW  = 2'b00,
        B_RISE = 2'b01,
        B_HIGH = 2'b10,
        B_FALL = 2'b11
    } btn_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             btn_s1_q, btn_s1_d;
    logic             btn_s2_q, btn_s2_d;
    logic             sw_s1_q, sw_s1_d;
    logic             sw_s2_q, sw_s2_d;
    btn_state_e       btn_state_q, btn_state_d;
    logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic             sw_lvl_q, sw_lvl_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic             next_pulse_q, next_pulse_d;
    logic [7:0]       press_count_q, press_count_d;
    logic             btn_done_s;
    logic             sw_done_s;

    // Two-flop synchronisers; only the second stage feeds the debouncers.
    always_comb begin
        btn_s1_d = bus.btn_next;
        btn_s2_d = btn_s1_q;
        sw_s1_d  = bus.sw_in;
        sw_s2_d  = sw_s1_q;
    end

    // Button debouncer as a four-state FSM; the press strobe and count
    // update on the same edge the level is accepted high.
    always_comb begin
        btn_state_d   = btn_state_q;
        btn_cnt_d     = btn_cnt_q;
        next_pulse_d  = 1'b0;
        press_count_d = press_count_q;
        btn_done_s    = (btn_cnt_q == CNT_MAX);
        case (btn_state_q)
            B_LOW: begin
                if (btn_s2_q) begin
                    btn_state_d = B_RISE;
                    btn_cnt_d   = btn_cnt_q + CNT_ONE;
                end else begin
                    btn_cnt_d   = CNT_ZERO;
                end
            end
            B_RISE: begin
                if (!btn_s2_q) begin
                    btn_state_d = B_LOW;
                    btn_cnt_d   = CNT_ZERO;
                end else if (btn_done_s) begin
                    btn_state_d   = B_HIGH;
                    btn_cnt_d     = CNT_ZERO;
                    next_pulse_d  = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                end else begin
                    btn_cnt_d   = btn_cnt_q + CNT_ONE;
                end
            end
            B_HIGH: begin
                if (!btn_s2_q) begin
                    btn_state_d = B_FALL;
                    btn_cnt_d   = btn_cnt_q + CNT_ONE;
                end else begin
                    btn_cnt_d   = CNT_ZERO;
                end
            end
            B_FALL: begin
                if (btn_s2_q) begin
                    btn_state_d = B_HIGH;
                    btn_cnt_d   = CNT_ZERO;
                end else if (btn_done_s) begin
                    btn_state_d = B_LOW;
                    btn_cnt_d   = CNT_ZERO;
                end else begin
                    btn_cnt_d   = btn_cnt_q + CNT_ONE;
                end
            end
            default: begin
                btn_state_d = B_LOW;
                btn_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Switch debouncer: same filtering rule, no strobe needed.
    always_comb begin
        sw_lvl_d  = sw_lvl_q;
        sw_cnt_d  = sw_cnt_q;
        sw_done_s = (sw_cnt_q == CNT_MAX);
        if (sw_s2_q == sw_lvl_q) begin
            sw_cnt_d = CNT_ZERO;
        end else if (sw_done_s) begin
            sw_lvl_d = sw_s2_q;
            sw_cnt_d = CNT_ZERO;
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
    end

    // State registers; reset clears everything without needing a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1_q      <= 1'b0;
            btn_s2_q      <= 1'b0;
            sw_s1_q       <= 1'b0;
            sw_s2_q       <= 1'b0;
            btn_state_q   <= B_LOW;
            btn_cnt_q     <= CNT_ZERO;
            sw_lvl_q      <= 1'b0;
            sw_cnt_q      <= CNT_ZERO;
            next_pulse_q  <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            sw_s1_q       <= sw_s1_d;
            sw_s2_q       <= sw_s2_d;
            btn_state_q   <= btn_state_d;
            btn_cnt_q     <= btn_cnt_d;
            sw_lvl_q      <= sw_lvl_d;
            sw_cnt_q      <= sw_cnt_d;
            next_pulse_q  <= next_pulse_d;
            press_count_q <= press_count_d;
        end
    end

    assign bus.next_level  = (btn_state_q == B_HIGH) || (btn_state_q == B_FALL);
    assign bus.next_pulse  = next_pulse_q;
    assign bus.in_sync     = sw_lvl_q;
    assign bus.press_count = press_count_q;

endmodule
